axi_slave_mem: RTL and testbench

- AXI3-style slave with one clock, five channels (AW, W, B, AR, R) and an internal word-organised RAM.
- Sits behind the bus-functional-model interface as the device under test; the master-side bench drives addresses and data and checks the responses.
- Write and read paths are independent state machines. Each path accepts one outstanding burst at a time.

---
 rtl/axi_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//   AXI3-style slave backed by a word-organised internal RAM. The write path
//   (AW/W/B) and the read path (AR/R) are independent state machines. Each
//   path accepts one outstanding burst at a time.
//
// Parameters
//   WIDTH     : data/address width; ID, LEN and STRB are WIDTH/8 bits wide
//   SIZE      : AxSIZE width; AxBURST and xRESP are SIZE-1 bits wide
//   MEM_DEPTH : number of WIDTH-bit words (power of two)
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   AW* / AWVALID / AWREADY    : write address channel
//   W* / WVALID / WREADY       : write data channel
//   BID/BRESP/BVALID/BREADY    : write response channel
//   AR* / ARVALID / ARREADY    : read address channel
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY : read data channel
//
// Optional feature
//   AXI_SLV_WLAST_CHECK_EN : when defined, a WLAST that does not line up with
//   the final beat of the write burst sets the write error flag (SLVERR).
//   When undefined, WLAST is ignored and the beat count ends the burst.
// ---------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 3,
  parameter int MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               reset,
  // write address
  input  logic [WIDTH/8-1:0] AWID,
  input  logic [WIDTH-1:0]   AWADDR,
  input  logic [WIDTH/8-1:0] AWLEN,
  input  logic [SIZE-1:0]    AWSIZE,
  input  logic [SIZE-2:0]    AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  // write data
  input  logic [WIDTH/8-1:0] WID,
  input  logic [WIDTH-1:0]   WDATA,
  input  logic [WIDTH/8-1:0] WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  // write response
  output logic [WIDTH/8-1:0] BID,
  output logic [SIZE-2:0]    BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  // read address
  input  logic [WIDTH/8-1:0] ARID,
  input  logic [WIDTH-1:0]   ARADDR,
  input  logic [WIDTH/8-1:0] ARLEN,
  input  logic [SIZE-1:0]    ARSIZE,
  input  logic [SIZE-2:0]    ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  // read data
  output logic [WIDTH/8-1:0] RID,
  output logic [WIDTH-1:0]   RDATA,
  output logic [SIZE-2:0]    RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY
);

  localparam int BW    = WIDTH / 8;          // bytes per word; ID/LEN/STRB width
  localparam int OFF_W = $clog2(BW);         // byte-offset bits within a word
  localparam int IDX_W = $clog2(MEM_DEPTH);  // word-index bits
  localparam int BT_W  = SIZE - 1;           // burst-type / response width

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(MEM_DEPTH * BW);

  localparam logic [BT_W-1:0] BURST_FIXED = BT_W'(0);
  localparam logic [BT_W-1:0] BURST_WRAP  = BT_W'(2);
  localparam logic [BT_W-1:0] BURST_RSVD  = '1;
  localparam logic [BT_W-1:0] RESP_OKAY   = BT_W'(0);
  localparam logic [BT_W-1:0] RESP_SLVERR = BT_W'(2);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] step_of(input logic [SIZE-1:0] size);
    return ONE << size;
  endfunction

  // WRAP bursts start on a beat-aligned address; other types start as given.
  function automatic logic [WIDTH-1:0] start_addr(input logic [WIDTH-1:0] addr,
                                                  input logic [SIZE-1:0]  size,
                                                  input logic [BT_W-1:0]  burst);
    if (burst == BURST_WRAP)
      return addr & ~(step_of(size) - ONE);
    return addr;
  endfunction

  // WRAP keeps the bits above the (LEN+1)*step window and lets the
  // incremented offset roll over inside it.
  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] addr,
                                                 input logic [BW-1:0]    len,
                                                 input logic [SIZE-1:0]  size,
                                                 input logic [BT_W-1:0]  burst);
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] span;
    inc  = addr + step_of(size);
    span = (WIDTH'(len) + ONE) << size;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~(span - ONE)) | (inc & (span - ONE));
      default:     next_addr = inc;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic addr_err(input logic [WIDTH-1:0] addr);
    return addr >= ADDR_LIMIT;
  endfunction

  // Burst-level errors: reserved type, WRAP with a non power-of-two length,
  // or a beat wider than the data bus.
  function automatic logic cfg_err(input logic [BW-1:0]   len,
                                   input logic [SIZE-1:0] size,
                                   input logic [BT_W-1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == BW'(1)) || (len == BW'(3)) ||
                  (len == BW'(7)) || (len == BW'(15));
    return (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !wrap_len_ok) ||
           (step_of(size) > WIDTH'(BW));
  endfunction

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  w_state_t         w_state;
  logic [BW-1:0]    w_id;
  logic [WIDTH-1:0] w_addr;
  logic [BW-1:0]    w_len;
  logic [SIZE-1:0]  w_size;
  logic [BT_W-1:0]  w_burst;
  logic [BW-1:0]    w_cnt;
  logic             w_err;
  logic             w_beat;
  logic             w_beat_err;
  logic             w_last_beat;
  logic             wlast_err;

  assign w_beat      = (w_state == W_DATA) && WREADY && WVALID;
  assign w_last_beat = (w_cnt == w_len);
  // Errors that suppress storing this particular beat.
  assign w_beat_err  = cfg_err(w_len, w_size, w_burst) | addr_err(w_addr) |
                       (WID != w_id);

`ifdef AXI_SLV_WLAST_CHECK_EN
  assign wlast_err = w_last_beat ? !WLAST : WLAST;
`else
  logic unused_wlast;
  assign unused_wlast = WLAST;
  assign wlast_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          AWREADY <= 1'b1;
          if (AWREADY && AWVALID) begin
            w_id    <= AWID;
            w_addr  <= start_addr(AWADDR, AWSIZE, AWBURST);
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_beat_err || wlast_err)
              w_err <= 1'b1;
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + BW'(1);
            if (w_last_beat) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= (w_err || w_beat_err || wlast_err) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled store; erroring beats and beats under reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_beat && !w_beat_err) begin
      for (int b = 0; b < BW; b++) begin
        if (WSTRB[b])
          mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  r_state_t         r_state;
  logic [WIDTH-1:0] r_addr;
  logic [BW-1:0]    r_len;
  logic [SIZE-1:0]  r_size;
  logic [BT_W-1:0]  r_burst;
  logic [BW-1:0]    r_cnt;
  logic [WIDTH-1:0] ar_start;
  logic [WIDTH-1:0] r_step_addr;
  logic [WIDTH-1:0] ld_addr;
  logic             ld_err;
  logic             ld_last;

  // "Load" = the beat to present next: the first beat straight from the AR
  // channel when idle, otherwise the successor of the beat on the bus.
  assign ar_start    = start_addr(ARADDR, ARSIZE, ARBURST);
  assign r_step_addr = next_addr(r_addr, r_len, r_size, r_burst);
  assign ld_addr     = (r_state == R_IDLE) ? ar_start : r_step_addr;
  assign ld_err      = (r_state == R_IDLE)
                       ? (cfg_err(ARLEN, ARSIZE, ARBURST) | addr_err(ar_start))
                       : (cfg_err(r_len, r_size, r_burst) | addr_err(r_step_addr));
  assign ld_last     = (r_state == R_IDLE) ? (ARLEN == '0)
                                           : ((r_cnt + BW'(1)) == r_len);

  // The RAM is read with a nonblocking sample, so a same-cycle write to the
  // same word is seen by the read only on the next access (old data wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ARREADY <= 1'b1;
          if (ARREADY && ARVALID) begin
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_addr  <= ld_addr;
            r_cnt   <= '0;
            RID     <= ARID;
            RDATA   <= ld_err ? '0 : mem[word_idx(ld_addr)];
            RRESP   <= ld_err ? RESP_SLVERR : RESP_OKAY;
            RLAST   <= ld_last;
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RVALID && RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= ld_addr;
              r_cnt  <= r_cnt + BW'(1);
              RDATA  <= ld_err ? '0 : mem[word_idx(ld_addr)];
              RRESP  <= ld_err ? RESP_SLVERR : RESP_OKAY;
              RLAST  <= ld_last;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mem
//   Directed testbench for axi_slave_mem (WIDTH=32, SIZE=3, MEM_DEPTH=256).
//   Drives AXI bursts from tasks and compares every response field against
//   hand-computed values. Ends with a single CHECKS/ERRORS summary line.
// ---------------------------------------------------------------------------
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  AWID, AWLEN, WID, WSTRB, BID, ARID, ARLEN, RID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, BRESP, ARBURST, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int errors = 0;
  logic [31:0] wd [16];
  logic [31:0] re [16];

  always #5 clk = ~clk;

  axi_slave_mem #(.WIDTH(32), .SIZE(3), .MEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic write_txn(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] strb,
                           input logic [3:0] wid, input int last_at,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin @(posedge clk); #1; n++; end
    if (!AWREADY) check({tag, "_awready"}, 32'(AWREADY), 32'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WID = wid; WDATA = wd[i]; WSTRB = strb; WLAST = (i == last_at); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 20) begin @(posedge clk); #1; n++; end
      if (!WREADY) check($sformatf("%s_wready%0d", tag, i), 32'(WREADY), 32'd1);
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    check({tag, "_bid"}, 32'(BID), 32'(id));
    check({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic read_txn(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [1:0] exp_resp,
                          input int stall_at, input string tag);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin @(posedge clk); #1; n++; end
    if (!ARREADY) check({tag, "_arready"}, 32'(ARREADY), 32'd1);
    @(posedge clk); #1;
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < 20) begin @(posedge clk); #1; n++; end
      check($sformatf("%s_rvalid%0d", tag, i), 32'(RVALID), 32'd1);
      check($sformatf("%s_rdata%0d", tag, i), RDATA, re[i]);
      check($sformatf("%s_rresp%0d", tag, i), 32'(RRESP), 32'(exp_resp));
      check($sformatf("%s_rid%0d", tag, i), 32'(RID), 32'(id));
      check($sformatf("%s_rlast%0d", tag, i), 32'(RLAST), 32'(i == int'(len)));
      if (i == stall_at) begin
        RREADY = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check($sformatf("%s_hold_rdata%0d", tag, i), RDATA, re[i]);
          check($sformatf("%s_hold_rlast%0d", tag, i), 32'(RLAST), 32'(i == int'(len)));
          check($sformatf("%s_hold_rvalid%0d", tag, i), 32'(RVALID), 32'd1);
        end
        RREADY = 1'b1;
      end
      @(posedge clk); #1;
    end
    RREADY = 1'b0;
    check({tag, "_rvalid_end"}, 32'(RVALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] wlast_resp;
    reset = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;

    // reset held two cycles: every output low
    @(posedge clk); #1;
    check("rst_ctrl1", {26'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 32'd0);
    check("rst_rdata1", RDATA, 32'd0);
    check("rst_ids1", {24'd0, BID, RID}, 32'd0);
    check("rst_resp1", {28'd0, BRESP, RRESP}, 32'd0);
    @(posedge clk); #1;
    check("rst_ctrl2", {26'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", 32'(AWREADY), 32'd1);
    check("post_rst_arready", 32'(ARREADY), 32'd1);

    // INCR write and matching read
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    write_txn(4'd3, 32'h10, 4'd3, 3'd2, 2'b01, 4'hF, 4'd3, 3, 2'b00, "incr_wr");
    re[0] = 32'hA0; re[1] = 32'hA1; re[2] = 32'hA2; re[3] = 32'hA3;
    read_txn(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 2'b00, -1, "incr_rd");

    // partial strobe over all-ones
    wd[0] = 32'hFFFF_FFFF;
    write_txn(4'd1, 32'h20, 4'd0, 3'd2, 2'b01, 4'hF, 4'd1, 0, 2'b00, "pre_ff");
    wd[0] = 32'h1122_3344;
    write_txn(4'd1, 32'h20, 4'd0, 3'd2, 2'b01, 4'b0101, 4'd1, 0, 2'b00, "strb_wr");
    re[0] = 32'hFF22_FF44;
    read_txn(4'd2, 32'h20, 4'd0, 3'd2, 2'b01, 2'b00, -1, "strb_rd");

    // WRAP read 0x18 -> 0x18, 0x1C, 0x10, 0x14
    re[0] = 32'hA2; re[1] = 32'hA3; re[2] = 32'hA0; re[3] = 32'hA1;
    read_txn(4'd6, 32'h18, 4'd3, 3'd2, 2'b10, 2'b00, -1, "wrap_rd");

    // out of range: 0x400 aliases word 0, which must stay untouched
    wd[0] = 32'h1234_5678;
    write_txn(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 4'hF, 4'd0, 0, 2'b00, "pre_w0");
    wd[0] = 32'hDEAD_BEEF;
    write_txn(4'd4, 32'h400, 4'd0, 3'd2, 2'b01, 4'hF, 4'd4, 0, 2'b10, "oor_wr");
    re[0] = 32'h1234_5678;
    read_txn(4'd4, 32'h0, 4'd0, 3'd2, 2'b01, 2'b00, -1, "oor_unchanged");
    re[0] = 32'h0;
    read_txn(4'd4, 32'h400, 4'd0, 3'd2, 2'b01, 2'b10, -1, "oor_rd");

    // reserved burst type
    wd[0] = 32'h2424_2424;
    write_txn(4'd7, 32'h24, 4'd0, 3'd2, 2'b01, 4'hF, 4'd7, 0, 2'b00, "pre_24");
    wd[0] = 32'hCAFE_F00D;
    write_txn(4'd7, 32'h24, 4'd0, 3'd2, 2'b11, 4'hF, 4'd7, 0, 2'b10, "rsvd_wr");
    re[0] = 32'h0;
    read_txn(4'd7, 32'h24, 4'd0, 3'd2, 2'b11, 2'b10, -1, "rsvd_rd");
    re[0] = 32'h2424_2424;
    read_txn(4'd7, 32'h24, 4'd0, 3'd2, 2'b01, 2'b00, -1, "rsvd_unchanged");

    // WID mismatch, oversize beat, illegal WRAP length
    wd[0] = 32'h5555_5555;
    write_txn(4'd8, 32'h28, 4'd0, 3'd2, 2'b01, 4'hF, 4'd9, 0, 2'b10, "wid_wr");
    re[0] = 32'h0;
    read_txn(4'd9, 32'h10, 4'd0, 3'd3, 2'b01, 2'b10, -1, "size_rd");
    re[0] = 32'h0; re[1] = 32'h0; re[2] = 32'h0;
    read_txn(4'd10, 32'h10, 4'd2, 3'd2, 2'b10, 2'b10, -1, "wraplen_rd");

    // FIXED burst: both beats land on the same word
    wd[0] = 32'hB0; wd[1] = 32'hB1;
    write_txn(4'd2, 32'h30, 4'd1, 3'd2, 2'b00, 4'hF, 4'd2, 1, 2'b00, "fixed_wr");
    re[0] = 32'hB1; re[1] = 32'hB1;
    read_txn(4'd2, 32'h30, 4'd1, 3'd2, 2'b00, 2'b00, -1, "fixed_rd");

    // RREADY low three cycles on beat 2 of 4
    re[0] = 32'hA0; re[1] = 32'hA1; re[2] = 32'hA2; re[3] = 32'hA3;
    read_txn(4'd11, 32'h10, 4'd3, 3'd2, 2'b01, 2'b00, 1, "stall_rd");

    // early WLAST on beat 2 of 4
`ifdef AXI_SLV_WLAST_CHECK_EN
    wlast_resp = 2'b10;
`else
    wlast_resp = 2'b00;
`endif
    wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
    write_txn(4'd12, 32'h40, 4'd3, 3'd2, 2'b01, 4'hF, 4'd12, 1, wlast_resp, "wlast_wr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
